// File: rtl/sequence_insertion_scheduler_if.sv
// ============================================================================
// Module      : sequence_insertion_scheduler_if
// Description : Sync, key handshake and generator-control bundle for the
//               sequence insertion scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sequence_insertion_scheduler_if;
  logic        frame_start;
  logic        line_start;
  logic        field;
  logic [31:0] seq_in;
  logic        seq_valid;
  logic        seq_ready;
  logic        gen_enable;
  logic        gen_load;
  logic [31:0] gen_sequence;
  logic        insert_active;
  logic        frame_done;
  logic        overrun_err;

  modport master (
    output frame_start, line_start, field, seq_in, seq_valid,
    input  seq_ready, gen_enable, gen_load, gen_sequence,
           insert_active, frame_done, overrun_err
  );

  modport slave (
    input  frame_start, line_start, field, seq_in, seq_valid,
    output seq_ready, gen_enable, gen_load, gen_sequence,
           insert_active, frame_done, overrun_err
  );
endinterface

`default_nettype wire

// File: rtl/sequence_insertion_scheduler.sv
// ============================================================================
// Module      : sequence_insertion_scheduler
// Description : Chooses the line/sample where the 40-bit ID+key burst is
//               inserted and drives sequence_generator enable/load/key.
//               Optional macro SEQ_BOTH_FIELDS_EN: insert in both fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_insertion_scheduler #(
  parameter logic [9:0]  INSERT_LINE   = 10'd20,
  parameter logic [10:0] SAMPLE_OFFSET = 11'd0,
  parameter logic [10:0] LOAD_LEN      = 11'd36,
  parameter logic [10:0] WINDOW_LEN    = 11'd1476
) (
  input  wire logic                     clock,
  input  wire logic                     rst,
  sequence_insertion_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_FRAME = 3'd0,
    COUNT      = 3'd1,
    ARMED      = 3'd2,
    LOAD       = 3'd3,
    SHIFT      = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] pending;
  logic        pending_full;
  logic        seq_ready;
  logic [31:0] gen_sequence;
  logic [9:0]  line_cnt;
  logic [9:0]  line_next;
  logic [10:0] sample_cnt;
  logic [10:0] win_cnt;
  logic        gen_enable;
  logic        gen_load;
  logic        insert_active;
  logic        frame_done;
  logic        overrun_err;
  logic        eligible;

  assign bus.seq_ready     = seq_ready;
  assign bus.gen_enable    = gen_enable;
  assign bus.gen_load      = gen_load;
  assign bus.gen_sequence  = gen_sequence;
  assign bus.insert_active = insert_active;
  assign bus.frame_done    = frame_done;
  assign bus.overrun_err   = overrun_err;

`ifdef SEQ_BOTH_FIELDS_EN
  assign eligible = 1'b1;
`else
  assign eligible = ~bus.field;
`endif

  // Line index this cycle's sync pulses will produce
  always_comb begin
    line_next = line_cnt;
    if (bus.frame_start) begin
      line_next = 10'd0;
    end else if (line_cnt != 10'h3FF) begin
      line_next = line_cnt + 10'd1;
    end
  end

  // Keys move to the generator only on frame_start, so a window never sees
  // its key change underneath it.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pending      <= 32'd0;
      pending_full <= 1'b0;
      seq_ready    <= 1'b1;
      gen_sequence <= 32'd0;
    end else if (bus.frame_start && pending_full) begin
      gen_sequence <= pending;
      pending_full <= 1'b0;
      seq_ready    <= 1'b1;
    end else if (bus.seq_valid && seq_ready) begin
      pending      <= bus.seq_in;
      pending_full <= 1'b1;
      seq_ready    <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      line_cnt   <= 10'd0;
      sample_cnt <= 11'd0;
    end else begin
      if (bus.frame_start || bus.line_start) begin
        line_cnt <= line_next;
      end
      if (bus.line_start) begin
        sample_cnt <= 11'd0;
      end else if (sample_cnt != 11'h7FF) begin
        sample_cnt <= sample_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state         <= WAIT_FRAME;
      win_cnt       <= 11'd0;
      gen_enable    <= 1'b0;
      gen_load      <= 1'b0;
      insert_active <= 1'b0;
      frame_done    <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          if (bus.frame_start) state <= COUNT;
        end
        COUNT: begin
          if (bus.line_start && (line_next == INSERT_LINE) && eligible) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (bus.line_start) begin
            overrun_err <= 1'b1;
            state       <= bus.frame_start ? COUNT : WAIT_FRAME;
          end else if (bus.frame_start) begin
            state <= COUNT;
          end else if (sample_cnt == SAMPLE_OFFSET) begin
            state         <= LOAD;
            win_cnt       <= 11'd1;
            gen_enable    <= 1'b1;
            gen_load      <= 1'b1;
            insert_active <= 1'b1;
          end
        end
        LOAD, SHIFT: begin
          // A line_start on the final window cycle still counts as completion
          if (bus.frame_start || (bus.line_start && (win_cnt != WINDOW_LEN))) begin
            gen_enable    <= 1'b0;
            gen_load      <= 1'b0;
            insert_active <= 1'b0;
            overrun_err   <= 1'b1;
            state         <= bus.frame_start ? COUNT : WAIT_FRAME;
          end else if (win_cnt == WINDOW_LEN) begin
            gen_enable    <= 1'b0;
            gen_load      <= 1'b0;
            insert_active <= 1'b0;
            frame_done    <= 1'b1;
            state         <= DONE;
          end else begin
            win_cnt <= win_cnt + 11'd1;
            if ((state == LOAD) && (win_cnt == LOAD_LEN)) begin
              gen_load <= 1'b0;
              state    <= SHIFT;
            end
          end
        end
        DONE: begin
          state <= bus.frame_start ? COUNT : WAIT_FRAME;
        end
        default: begin
          state <= WAIT_FRAME;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sequence_insertion_scheduler.sv
// ============================================================================
// Module      : tb_sequence_insertion_scheduler
// Description : Self-checking bench for sequence_insertion_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequence_insertion_scheduler;

  localparam int INSERT_LINE   = 20;
  localparam int SAMPLE_OFFSET = 0;
  localparam int LOAD_LEN      = 36;
  localparam int WINDOW_LEN    = 1476;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  sequence_insertion_scheduler_if bus ();

  sequence_insertion_scheduler dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the window is a planned range of absolute cycle numbers
  // derived from when the target line_start arrives; sync pulses that land
  // inside that range truncate it.
  longint      cyc      = 0;
  bit          live     = 0;
  longint      arm_e    = 0;
  longint      p_start  = -10;
  longint      p_end    = -20;
  bit          counting = 0;
  int          lines    = 0;
  bit          m_done   = 0;
  bit          m_ovr    = 0;
  bit          m_en     = 0;
  bit          m_load   = 0;
  logic [31:0] m_key    = '0;
  logic [31:0] m_pend   = '0;
  bit          m_pfull  = 0;

  task automatic model_step();
    bit fs, ls, elig, in_win, armed;
    cyc++;
    if (rst) begin
      live = 0; counting = 0; lines = 0; p_start = -10; p_end = -20;
      m_done = 0; m_ovr = 0; m_key = '0; m_pend = '0; m_pfull = 0;
      m_en = 0; m_load = 0;
      return;
    end
    fs = bus.frame_start;
    ls = bus.line_start;
`ifdef SEQ_BOTH_FIELDS_EN
    elig = 1'b1;
`else
    elig = (bus.field == 1'b0);
`endif
    if (fs && m_pfull) begin
      m_key = m_pend; m_pfull = 0;
    end else if (bus.seq_valid && !m_pfull) begin
      m_pend = bus.seq_in; m_pfull = 1;
    end
    m_done = 0;
    if (live) begin
      in_win = (cyc - 1 >= p_start) && (cyc - 1 <= p_end);
      armed  = (cyc - 1 >= arm_e) && (cyc - 1 < p_start);
      if (in_win && fs) begin
        p_end = cyc - 1; m_ovr = 1; live = 0;
      end else if ((armed || in_win) && ls && (cyc != p_end + 1)) begin
        p_end = cyc - 1; m_ovr = 1; live = 0;
      end else if (armed && fs) begin
        p_end = -20; live = 0;
      end else if (cyc == p_end + 1) begin
        m_done = 1; live = 0;
      end
    end
    if (fs) begin
      counting = 1; lines = 0;
    end else if (ls && counting) begin
      lines++;
      if (lines == INSERT_LINE) begin
        counting = 0;
        if (elig) begin
          live    = 1;
          arm_e   = cyc;
          p_start = cyc + 1 + SAMPLE_OFFSET;
          p_end   = p_start + WINDOW_LEN - 1;
        end
      end
    end
    m_en   = (cyc >= p_start) && (cyc <= p_end);
    m_load = m_en && (cyc < p_start + LOAD_LEN);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  int en_total   = 0;
  int load_total = 0;
  int done_total = 0;

  initial forever begin
    @(negedge clock);
    if (!rst) begin
      check1 ("gen_enable",    bus.gen_enable,    m_en);
      check1 ("gen_load",      bus.gen_load,      m_load);
      check1 ("insert_active", bus.insert_active, m_en);
      check1 ("frame_done",    bus.frame_done,    m_done);
      check1 ("overrun_err",   bus.overrun_err,   m_ovr);
      check1 ("seq_ready",     bus.seq_ready,     !m_pfull);
      check32("gen_sequence",  bus.gen_sequence,  m_key);
      en_total   += int'(bus.gen_enable);
      load_total += int'(bus.gen_load);
      done_total += int'(bus.frame_done);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic line_pulse(input int period);
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    repeat (period - 1) tick();
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  int b_en, b_load, b_done;
  task automatic snap();
    b_en = en_total; b_load = load_total; b_done = done_total;
  endtask

  int exp_field1;

  initial begin
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
    bus.field       = 1'b0;
    bus.seq_in      = 32'd0;
    bus.seq_valid   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check1 ("reset gen_enable",   bus.gen_enable,   1'b0);
    check1 ("reset gen_load",     bus.gen_load,     1'b0);
    check1 ("reset frame_done",   bus.frame_done,   1'b0);
    check1 ("reset overrun_err",  bus.overrun_err,  1'b0);
    check1 ("reset seq_ready",    bus.seq_ready,    1'b1);
    check32("reset gen_sequence", bus.gen_sequence, 32'd0);

    // Full-length frame with the standard line period
    bus.seq_in = 32'hA5A5_1234; bus.seq_valid = 1'b1;
    tick();
    bus.seq_valid = 1'b0;
    check1("s1 ready after push", bus.seq_ready, 1'b0);
    frame_pulse();
    check32("s1 key applied", bus.gen_sequence, 32'hA5A5_1234);
    check1 ("s1 ready freed", bus.seq_ready, 1'b1);
    snap();
    repeat (INSERT_LINE - 1) line_pulse(1716);
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    check1("s1 enable not yet", bus.gen_enable, 1'b0);
    tick();
    check1("s1 enable rises", bus.gen_enable, 1'b1);
    check1("s1 load rises",   bus.gen_load,   1'b1);
    repeat (1714) tick();
    line_pulse(4);
    check32("s1 enable cycles", 32'(en_total - b_en),     32'd1476);
    check32("s1 load cycles",   32'(load_total - b_load), 32'd36);
    check32("s1 done pulses",   32'(done_total - b_done), 32'd1);
    check1 ("s1 overrun",       bus.overrun_err, 1'b0);

    // Second word is held off until the pending word is consumed
    bus.seq_in = 32'h1; bus.seq_valid = 1'b1;
    tick();
    bus.seq_in = 32'h2;
    tick();
    check1 ("s2 ready busy", bus.seq_ready, 1'b0);
    tick();
    check32("s2 key held", bus.gen_sequence, 32'hA5A5_1234);
    frame_pulse();
    check32("s2 key 1 applied", bus.gen_sequence, 32'h1);
    check1 ("s2 ready back",    bus.seq_ready,    1'b1);
    tick();
    bus.seq_valid = 1'b0;
    check1 ("s2 word 2 taken",  bus.seq_ready,    1'b0);

    // frame_start 500 cycles into the window, then a clean frame
    frame_pulse();
    check32("s4 key 2 applied", bus.gen_sequence, 32'h2);
    snap();
    repeat (INSERT_LINE - 1) line_pulse(20);
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    repeat (500) tick();
    frame_pulse();
    check1 ("s4 enable dropped", bus.gen_enable,  1'b0);
    check1 ("s4 overrun",        bus.overrun_err, 1'b1);
    check32("s4 enable cycles",  32'(en_total - b_en),     32'd500);
    check32("s4 no done",        32'(done_total - b_done), 32'd0);
    snap();
    repeat (INSERT_LINE - 1) line_pulse(20);
    line_pulse(1716);
    check32("s4 next enable cycles", 32'(en_total - b_en),     32'd1476);
    check32("s4 next done",          32'(done_total - b_done), 32'd1);

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check1("overrun cleared by rst", bus.overrun_err, 1'b0);

    // Short target line: next line_start cuts the window
    frame_pulse();
    snap();
    repeat (INSERT_LINE - 1) line_pulse(20);
    line_pulse(1000);
    line_pulse(4);
    check32("s3 enable cycles", 32'(en_total - b_en),     32'd999);
    check32("s3 no done",       32'(done_total - b_done), 32'd0);
    check1 ("s3 overrun",       bus.overrun_err, 1'b1);

    // Second field on the target line
`ifdef SEQ_BOTH_FIELDS_EN
    exp_field1 = 1476;
`else
    exp_field1 = 0;
`endif
    bus.field = 1'b1;
    frame_pulse();
    snap();
    repeat (INSERT_LINE - 1) line_pulse(20);
    line_pulse(1716);
    line_pulse(4);
    bus.field = 1'b0;
    check32("s5 field1 enable cycles", 32'(en_total - b_en), 32'(exp_field1));

    // Reset 700 cycles into the window
    frame_pulse();
    repeat (INSERT_LINE - 1) line_pulse(20);
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    repeat (700) tick();
    check1("s6 in window", bus.gen_enable, 1'b1);
    rst = 1'b1;
    #1;
    check1 ("s6 async enable",  bus.gen_enable,    1'b0);
    check1 ("s6 async load",    bus.gen_load,      1'b0);
    check1 ("s6 async insert",  bus.insert_active, 1'b0);
    check1 ("s6 async ready",   bus.seq_ready,     1'b1);
    check1 ("s6 async overrun", bus.overrun_err,   1'b0);
    check32("s6 async key",     bus.gen_sequence,  32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    snap();
    repeat (25) line_pulse(20);
    check32("s6 no window without frame", 32'(en_total - b_en), 32'd0);
    frame_pulse();
    snap();
    repeat (INSERT_LINE - 1) line_pulse(20);
    line_pulse(1716);
    check32("s6 window after frame", 32'(en_total - b_en),     32'd1476);
    check32("s6 done after frame",   32'(done_total - b_done), 32'd1);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
